snapshot_edgesel_ctrl: RTL and testbench

Calibration and tracking controller for the FREF/CKV snapshot retimer's EDGESEL input. Runs in the retimed-reference domain (CKR). It measures the per-reference-period CKV count increment under each edge setting, counts increments that deviate from the expected integer FCW, and selects the edge with fewer outliers. After lock it keeps monitoring and flags a recalibration or restarts one when outliers exceed a threshold.

---
 rtl/snapshot_edgesel_ctrl_if.sv | 44 ++++
 rtl/snapshot_edgesel_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_snapshot_edgesel_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/snapshot_edgesel_ctrl_if.sv
// -----------------------------------------------------------------------------
// snapshot_edgesel_ctrl_if
// Groups the control and status signals of the EDGESEL calibration controller.
// The clock (CKR) and reset (NRST) are plain module ports and are not part of
// this bundle.
//
//   EN         block enable (low holds the controller in IDLE)
//   CAL_START  single-cycle calibration request
//   FCW_INT    expected CKV cycles per reference period, integer part
//   CNT        CKV counter value sampled at CKR_CNT
//   EDGESEL    edge select driven to the snapshot retimer
//   CAL_BUSY   calibration in progress
//   CAL_DONE   one-cycle pulse on the DECIDE cycle
//   ERR0/ERR1  outlier counts captured under EDGESEL=0 / EDGESEL=1
//   RECAL_REQ  one-cycle pulse when a tracking window fails
//
// master: the side that drives requests and the counter sample (system side).
// slave : the controller itself.
// -----------------------------------------------------------------------------
interface snapshot_edgesel_ctrl_if #(
   parameter int CNT_W = 10,
   parameter int WIN_W = 6
);
   logic             EN;
   logic             CAL_START;
   logic [CNT_W-1:0] FCW_INT;
   logic [CNT_W-1:0] CNT;
   logic             EDGESEL;
   logic             CAL_BUSY;
   logic             CAL_DONE;
   logic [WIN_W:0]   ERR0;
   logic [WIN_W:0]   ERR1;
   logic             RECAL_REQ;

   modport master (
      output EN, CAL_START, FCW_INT, CNT,
      input  EDGESEL, CAL_BUSY, CAL_DONE, ERR0, ERR1, RECAL_REQ
   );

   modport slave (
      input  EN, CAL_START, FCW_INT, CNT,
      output EDGESEL, CAL_BUSY, CAL_DONE, ERR0, ERR1, RECAL_REQ
   );
endinterface

// File: rtl/snapshot_edgesel_ctrl.sv
// -----------------------------------------------------------------------------
// snapshot_edgesel_ctrl
// Calibration and tracking controller for the EDGESEL input of the FREF/CKV
// snapshot retimer. Runs in the retimed-reference (CKR) domain.
//
// For each edge setting it waits SETTLE cycles, primes the previous-count
// register, then measures 2^WIN_W per-period CKV count increments and counts
// those differing from FCW_INT. The edge with fewer outliers wins (tie -> 0).
// After lock it keeps measuring back-to-back windows and raises RECAL_REQ
// when a window holds more than TRK_TH outliers.
//
// Ports:
//   CKR   in  reference clock, all logic on posedge
//   NRST  in  asynchronous active-low reset
//   ctl   slave modport of snapshot_edgesel_ctrl_if (EN, CAL_START, FCW_INT,
//         CNT in; EDGESEL, CAL_BUSY, CAL_DONE, ERR0, ERR1, RECAL_REQ out)
// -----------------------------------------------------------------------------
module snapshot_edgesel_ctrl #(
   parameter int CNT_W      = 10,
   parameter int WIN_W      = 6,
   parameter int SETTLE     = 4,
   parameter int TRK_TH     = 2,
   parameter bit AUTO_RECAL = 1'b1
) (
   input  logic                   CKR,
   input  logic                   NRST,
   snapshot_edgesel_ctrl_if.slave ctl
);

   localparam int ERR_W = WIN_W + 1;
   localparam int SET_W = 4;
   localparam logic [ERR_W-1:0] ERR_MAX = {1'b1, {WIN_W{1'b0}}};

   typedef enum logic [3:0] {
      S_IDLE,
      S_SET0,
      S_PRIME0,
      S_MEAS0,
      S_SET1,
      S_PRIME1,
      S_MEAS1,
      S_DECIDE,
      S_TRACK
   } state_t;

   state_t             r_state;
   state_t             w_next;

   logic [CNT_W-1:0]   r_prev;
   logic [SET_W-1:0]   r_settle;
   logic [WIN_W-1:0]   r_win_cnt;
   logic [ERR_W-1:0]   r_err_cnt;
   logic               r_trk_primed;

   logic               r_edgesel;
   logic               r_cal_busy;
   logic               r_cal_done;
   logic               r_recal_req;
   logic [ERR_W-1:0]   r_err0;
   logic [ERR_W-1:0]   r_err1;

   logic [CNT_W-1:0]   w_delta;
   logic               w_outlier;
   logic               w_win_last;
   logic               w_counting;
   logic               w_sampling;
   logic               w_in_set;
   logic [ERR_W-1:0]   w_err_inc;
   logic               w_trk_fail;

   // --------------------------------------------------------------------------
   // Next-state and datapath decode
   // --------------------------------------------------------------------------
   // NOTE: every signal of this block is given a default before any branch so
   // that no path leaves it unassigned; otherwise a latch would be inferred.
   always_comb begin
      // Modular subtraction makes counter rollover transparent.
      w_delta    = ctl.CNT - r_prev;
      w_outlier  = (w_delta != ctl.FCW_INT);
      w_win_last = &r_win_cnt;
      w_in_set   = (r_state == S_SET0) || (r_state == S_SET1);

      // The first TRACK cycle only primes r_prev, like PRIMEx.
      w_counting = (r_state == S_MEAS0) || (r_state == S_MEAS1) ||
                   ((r_state == S_TRACK) && r_trk_primed);
      w_sampling = w_counting || (r_state == S_PRIME0) ||
                   (r_state == S_PRIME1) || (r_state == S_TRACK);

      // Running count including this cycle's outlier, saturating at 2^WIN_W.
      if (r_err_cnt == ERR_MAX) begin
         w_err_inc = r_err_cnt;
      end else begin
         w_err_inc = r_err_cnt + ERR_W'(w_outlier);
      end

      w_trk_fail = (r_state == S_TRACK) && r_trk_primed && w_win_last &&
                   (w_err_inc > ERR_W'(TRK_TH));

      w_next = r_state;
      if (!ctl.EN) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:   if (ctl.CAL_START) w_next = S_SET0;
            S_SET0:   if (r_settle == SET_W'(SETTLE - 1)) w_next = S_PRIME0;
            S_PRIME0: w_next = S_MEAS0;
            S_MEAS0:  if (w_win_last) w_next = S_SET1;
            S_SET1:   if (r_settle == SET_W'(SETTLE - 1)) w_next = S_PRIME1;
            S_PRIME1: w_next = S_MEAS1;
            S_MEAS1:  if (w_win_last) w_next = S_DECIDE;
            S_DECIDE: w_next = S_TRACK;
            S_TRACK: begin
               if (ctl.CAL_START || (w_trk_fail && AUTO_RECAL)) w_next = S_SET0;
            end
            default:  w_next = S_IDLE;
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // State, counters and registered outputs
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CKR or negedge NRST) begin
      if (!NRST) begin
         r_state      <= S_IDLE;
         r_prev       <= '0;
         r_settle     <= '0;
         r_win_cnt    <= '0;
         r_err_cnt    <= '0;
         r_trk_primed <= 1'b0;
         r_edgesel    <= 1'b0;
         r_cal_busy   <= 1'b0;
         r_cal_done   <= 1'b0;
         r_recal_req  <= 1'b0;
         r_err0       <= '0;
         r_err1       <= '0;
      end else begin
         r_state <= w_next;

         // Busy drops when entering DECIDE so it is already low while
         // CAL_DONE pulses; it stays low through TRACK.
         r_cal_busy  <= (w_next != S_IDLE) && (w_next != S_DECIDE) &&
                        (w_next != S_TRACK);
         r_cal_done  <= (w_next == S_DECIDE);
         r_recal_req <= ctl.EN && w_trk_fail;

         // EDGESEL moves only on SETx entry and when leaving DECIDE.
         if (w_next == S_SET0) begin
            r_edgesel <= 1'b0;
         end else if (w_next == S_SET1) begin
            r_edgesel <= 1'b1;
         end else if ((r_state == S_DECIDE) && (w_next == S_TRACK)) begin
            r_edgesel <= (r_err0 <= r_err1) ? 1'b0 : 1'b1;
         end

         if (!ctl.EN) begin
            // EDGESEL, ERR0 and ERR1 are deliberately left untouched.
            r_prev       <= '0;
            r_settle     <= '0;
            r_win_cnt    <= '0;
            r_err_cnt    <= '0;
            r_trk_primed <= 1'b0;
         end else begin
            if (w_sampling) r_prev <= ctl.CNT;

            r_settle     <= (w_in_set && (w_next == r_state)) ?
                            r_settle + SET_W'(1) : '0;
            r_win_cnt    <= w_counting ? r_win_cnt + WIN_W'(1) : '0;
            // Cleared outside measurement, so each window starts from zero.
            r_err_cnt    <= (w_counting && !w_win_last) ? w_err_inc : '0;
            r_trk_primed <= (r_state == S_TRACK) && (w_next == S_TRACK);

            if ((r_state == S_MEAS0) && w_win_last) r_err0 <= w_err_inc;
            if ((r_state == S_MEAS1) && w_win_last) r_err1 <= w_err_inc;
         end
      end
   end

   assign ctl.EDGESEL   = r_edgesel;
   assign ctl.CAL_BUSY  = r_cal_busy;
   assign ctl.CAL_DONE  = r_cal_done;
   assign ctl.ERR0      = r_err0;
   assign ctl.ERR1      = r_err1;
   assign ctl.RECAL_REQ = r_recal_req;

endmodule

// File: tb/tb_snapshot_edgesel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snapshot_edgesel_ctrl
// Two controllers share one stimulus: u_dut_a restarts calibration on a
// tracking failure, u_dut_b only flags it. Expected values come from the
// timeline of a calibration (SET, PRIME, MEAS per edge, then DECIDE) and the
// increments the bench itself drives: a measured delta equals the increment
// applied in that cycle, so outliers are counted straight from the stimulus.
// -----------------------------------------------------------------------------
module tb_snapshot_edgesel_ctrl;

   localparam int CNT_W  = 10;
   localparam int WIN_W  = 6;
   localparam int SETTLE = 4;
   localparam int TRK_TH = 2;
   localparam int WIN    = 1 << WIN_W;
   localparam int L      = SETTLE + 1 + WIN;      // cycles per edge phase
   localparam int J_DEC  = 2 * L;                 // DECIDE offset from SET0
   localparam int M0_LO  = SETTLE + 1;
   localparam int M0_HI  = L - 1;
   localparam int M1_LO  = L + SETTLE + 1;
   localparam int M1_HI  = 2 * L - 1;

   logic ckr;
   logic nrst;

   int total = 0;
   int bad   = 0;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] fcw;
   int               m_err0;
   int               m_err1;
   logic             m_sel;
   logic             m_sel_b;

   snapshot_edgesel_ctrl_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus_a ();
   snapshot_edgesel_ctrl_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus_b ();

   assign bus_b.EN        = bus_a.EN;
   assign bus_b.CAL_START = bus_a.CAL_START;
   assign bus_b.FCW_INT   = bus_a.FCW_INT;
   assign bus_b.CNT       = bus_a.CNT;

   snapshot_edgesel_ctrl #(
      .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE(SETTLE), .TRK_TH(TRK_TH),
      .AUTO_RECAL(1'b1)
   ) u_dut_a (
      .CKR (ckr),
      .NRST(nrst),
      .ctl (bus_a)
   );

   snapshot_edgesel_ctrl #(
      .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE(SETTLE), .TRK_TH(TRK_TH),
      .AUTO_RECAL(1'b0)
   ) u_dut_b (
      .CKR (ckr),
      .NRST(nrst),
      .ctl (bus_b)
   );

   initial ckr = 1'b0;
   always #5 ckr = ~ckr;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance the counter by inc, present it for one cycle, land #1 after the
   // next rising edge.
   task automatic do_cycle(input logic [CNT_W-1:0] inc, input logic start);
      cnt_q = cnt_q + inc;
      bus_a.CNT       = cnt_q;
      bus_a.CAL_START = start;
      @(posedge ckr);
      #1;
   endtask

   // mode 0: clean; 1: alternating +-1 under edge 0, clean under edge 1;
   // 2: random outliers with percentage p0 (edge 0 phase) / p1 (edge 1 phase).
   function automatic logic [CNT_W-1:0] inc_for(input int mode, input int j,
                                                input int p0, input int p1);
      int pct;
      if (mode == 1) begin
         if (j < L) return (j % 2 == 1) ? fcw - CNT_W'(1) : fcw + CNT_W'(1);
         return fcw;
      end
      if (mode == 2) begin
         pct = (j < L) ? p0 : p1;
         if (int'($urandom_range(99, 0)) < pct)
            return fcw + CNT_W'($urandom_range(9, 1));
      end
      return fcw;
   endfunction

   // Runs one calibration on u_dut_a. abort_kind 1 drops EN at abort_j,
   // abort_kind 2 pulses NRST at abort_j. stray_j pulses CAL_START mid-run.
   task automatic run_cal(input int mode, input bit need_start, input int p0,
                          input int p1, input int stray_j, input int abort_j,
                          input int abort_kind);
      int e0;
      int e1;
      logic [CNT_W-1:0] inc;
      e0 = 0;
      e1 = 0;
      if (need_start) do_cycle(fcw, 1'b1);
      for (int j = 0; j <= J_DEC; j++) begin
         if (j < J_DEC) check("cal_busy", 32'(bus_a.CAL_BUSY), 32'd1);
         check("cal_done", 32'(bus_a.CAL_DONE), 32'(j == J_DEC));
         if (j < J_DEC) check("edgesel_cal", 32'(bus_a.EDGESEL), 32'(j >= L));
         if (j == L) begin
            m_err0 = e0;
            check("err0", 32'(bus_a.ERR0), m_err0);
         end
         if (j == J_DEC) begin
            m_err1 = e1;
            check("err1", 32'(bus_a.ERR1), m_err1);
         end
         if (j == abort_j && abort_kind == 1) begin
            bus_a.EN = 1'b0;
            do_cycle(fcw, 1'b0);
            m_sel = 1'b1;
            check("en_abort_busy", 32'(bus_a.CAL_BUSY), 32'd0);
            check("en_abort_edgesel", 32'(bus_a.EDGESEL), 32'(m_sel));
            check("en_abort_err0", 32'(bus_a.ERR0), m_err0);
            check("en_abort_err1", 32'(bus_a.ERR1), m_err1);
            bus_a.EN = 1'b1;
            do_cycle(fcw, 1'b0);
            check("en_abort_idle", 32'(bus_a.CAL_BUSY), 32'd0);
            return;
         end
         if (j == abort_j && abort_kind == 2) begin
            nrst = 1'b0;
            #2;
            check("rst_abort_busy", 32'(bus_a.CAL_BUSY), 32'd0);
            check("rst_abort_done", 32'(bus_a.CAL_DONE), 32'd0);
            check("rst_abort_edgesel", 32'(bus_a.EDGESEL), 32'd0);
            check("rst_abort_err0", 32'(bus_a.ERR0), 32'd0);
            check("rst_abort_err1", 32'(bus_a.ERR1), 32'd0);
            check("rst_abort_recal", 32'(bus_a.RECAL_REQ), 32'd0);
            #2;
            nrst = 1'b1;
            @(posedge ckr);
            #1;
            check("rst_abort_idle", 32'(bus_a.CAL_BUSY), 32'd0);
            m_err0 = 0;
            m_err1 = 0;
            m_sel  = 1'b0;
            return;
         end
         inc = inc_for(mode, j, p0, p1);
         if (j >= M0_LO && j <= M0_HI && inc != fcw) e0++;
         if (j >= M1_LO && j <= M1_HI && inc != fcw) e1++;
         do_cycle(inc, 1'(j == stray_j));
      end
      // First TRACK cycle.
      m_sel = (m_err0 <= m_err1) ? 1'b0 : 1'b1;
      check("lock_edgesel", 32'(bus_a.EDGESEL), 32'(m_sel));
      check("lock_busy", 32'(bus_a.CAL_BUSY), 32'd0);
      check("lock_done", 32'(bus_a.CAL_DONE), 32'd0);
   endtask

   // One tracking window with nbad outlier increments; optional prime cycle.
   task automatic track(input bit prime, input int nbad);
      int  base;
      bit  fail;
      logic [CNT_W-1:0] inc;
      fail = (nbad > TRK_TH);
      // A wild increment in the prime cycle must not be counted.
      if (prime) do_cycle(fcw + CNT_W'(37), 1'b0);
      base = int'($urandom_range(WIN - 1 - 2 * nbad, 0));
      for (int w = 0; w < WIN; w++) begin
         if (w == 0) check("recal_idle_a", 32'(bus_a.RECAL_REQ), 32'd0);
         inc = fcw;
         if (w >= base && w < base + 2 * nbad && (w - base) % 2 == 0)
            inc = fcw + CNT_W'(3);
         do_cycle(inc, 1'b0);
      end
      check("recal_a", 32'(bus_a.RECAL_REQ), 32'(fail));
      check("recal_b", 32'(bus_b.RECAL_REQ), 32'(fail));
      check("recal_busy_a", 32'(bus_a.CAL_BUSY), 32'(fail));
      check("recal_edgesel_a", 32'(bus_a.EDGESEL), fail ? 32'd0 : 32'(m_sel));
      check("recal_busy_b", 32'(bus_b.CAL_BUSY), 32'd0);
      check("recal_edgesel_b", 32'(bus_b.EDGESEL), 32'(m_sel_b));
   endtask

   initial begin
      int p0;
      int p1;
      nrst = 1'b1;
      bus_a.EN        = 1'b1;
      bus_a.CAL_START = 1'b0;
      fcw             = CNT_W'(100);
      bus_a.FCW_INT   = fcw;
      cnt_q           = '0;
      bus_a.CNT       = cnt_q;
      m_err0 = 0;
      m_err1 = 0;
      m_sel  = 1'b0;
      m_sel_b = 1'b0;
      #1 nrst = 1'b0;
      #10;
      check("rst_edgesel", 32'(bus_a.EDGESEL), 32'd0);
      check("rst_busy", 32'(bus_a.CAL_BUSY), 32'd0);
      check("rst_done", 32'(bus_a.CAL_DONE), 32'd0);
      check("rst_err0", 32'(bus_a.ERR0), 32'd0);
      check("rst_err1", 32'(bus_a.ERR1), 32'd0);
      check("rst_recal", 32'(bus_a.RECAL_REQ), 32'd0);
      @(negedge ckr);
      nrst = 1'b1;
      @(posedge ckr);
      #1;
      check("idle_busy", 32'(bus_a.CAL_BUSY), 32'd0);

      // Clean lock, with a stray CAL_START during MEAS0 that must be ignored.
      run_cal(0, 1'b1, 0, 0, 20, -1, 0);
      check("clean_err0", 32'(bus_a.ERR0), 32'd0);

      // Metastable edge 0, started from TRACK.
      run_cal(1, 1'b1, 0, 0, -1, -1, 0);
      check("meta_err0", 32'(bus_a.ERR0), 32'd64);
      check("meta_sel", 32'(bus_a.EDGESEL), 32'd1);
      m_sel_b = m_sel;

      // Tracking: TRK_TH outliers pass, TRK_TH+1 fail.
      track(1'b1, TRK_TH);
      track(1'b0, TRK_TH + 1);

      // u_dut_a reruns from SET0 on its own; u_dut_b stays locked.
      run_cal(0, 1'b0, 0, 0, -1, -1, 0);
      check("b_still_track", 32'(bus_b.CAL_BUSY), 32'd0);
      check("b_keeps_edgesel", 32'(bus_b.EDGESEL), 32'(m_sel_b));

      // Rollover: 1016 -> 1024 wraps to 0 inside MEAS0, again inside MEAS1.
      fcw           = CNT_W'(8);
      bus_a.FCW_INT = fcw;
      cnt_q         = CNT_W'(960);
      run_cal(0, 1'b1, 0, 0, -1, -1, 0);
      check("wrap_err0", 32'(bus_a.ERR0), 32'd0);
      check("wrap_err1", 32'(bus_a.ERR1), 32'd0);

      // Random calibrations; the second one is aborted by EN in MEAS1.
      for (int r = 0; r < 3; r++) begin
         fcw           = CNT_W'($urandom);
         bus_a.FCW_INT = fcw;
         p0 = int'($urandom_range(30, 0));
         p1 = int'($urandom_range(30, 0));
         run_cal(2, 1'b1, p0, p1, -1, (r == 1) ? 100 : -1, (r == 1) ? 1 : 0);
      end

      // Reset in MEAS0 after a calibration that left ERR0 at 64.
      fcw           = CNT_W'(100);
      bus_a.FCW_INT = fcw;
      run_cal(1, 1'b1, 0, 0, -1, -1, 0);
      run_cal(1, 1'b1, 0, 0, -1, 30, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
